// File: rtl/multicycle_main_control.sv
// -----------------------------------------------------------------------------
// multicycle_main_control
//   Moore main control FSM for the multicycle MIPS datapath. Walks each
//   instruction through fetch / decode / execute / memory / writeback, drives
//   the ALUOp code, all datapath mux selects and write strobes, stalls on the
//   memory-ready handshake, flags unsupported opcodes and counts retirements.
//
// Ports
//   i_Clk          rising-edge clock
//   i_Rst_n        asynchronous active-low reset
//   i_Opcode       instruction[31:26] from the IR (used in DECODE and MEMADDR)
//   i_MemReady     memory finished the current access this cycle
//   o_ALUOp        00 add, 01 subtract, 10 R-type funct decode
//   o_ALUSrcA      0 PC, 1 register A
//   o_ALUSrcB      00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//   o_PCSource     00 ALU result, 01 ALUOut, 10 jump target
//   o_PCWrite      unconditional PC write
//   o_PCWriteCond  PC write when ALU zero
//   o_IorD         memory address select: 0 PC, 1 ALUOut
//   o_MemRead      memory read request
//   o_MemWrite     memory write request
//   o_IRWrite      instruction register load
//   o_MemtoReg     writeback data: 0 ALUOut, 1 MDR
//   o_RegDst       destination register: 0 rt, 1 rd
//   o_RegWrite     register file write
//   o_IllegalOp    registered one-cycle pulse after an unsupported opcode
//   o_State        current state encoding (debug)
//   o_InstrCount   retired instruction count, wraps modulo 2^COUNT_W
// -----------------------------------------------------------------------------
module multicycle_main_control #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic [5:0]         i_Opcode,
  input  logic               i_MemReady,
  output logic [1:0]         o_ALUOp,
  output logic               o_ALUSrcA,
  output logic [1:0]         o_ALUSrcB,
  output logic [1:0]         o_PCSource,
  output logic               o_PCWrite,
  output logic               o_PCWriteCond,
  output logic               o_IorD,
  output logic               o_MemRead,
  output logic               o_MemWrite,
  output logic               o_IRWrite,
  output logic               o_MemtoReg,
  output logic               o_RegDst,
  output logic               o_RegWrite,
  output logic               o_IllegalOp,
  output logic [3:0]         o_State,
  output logic [COUNT_W-1:0] o_InstrCount
);

  localparam int unsigned STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_RWB      = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11
  } state_t;

  state_t             r_State;
  state_t             w_NextState;
  logic               w_Illegal;
  logic               w_Retire;
  logic               r_IllegalOp;
  logic [COUNT_W-1:0] r_InstrCount;

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State <= S_FETCH;
    end else begin
      r_State <= w_NextState;
    end
  end

  // Next-state logic, illegal-opcode detect and retirement detect
  always_comb begin
    w_NextState = S_FETCH;
    w_Illegal   = 1'b0;
    w_Retire    = 1'b0;
    case (r_State)
      S_FETCH: begin
        w_NextState = i_MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        case (i_Opcode)
          OP_LW, OP_SW: w_NextState = S_MEMADDR;
          OP_RTYPE:     w_NextState = S_EXECUTE;
          OP_BEQ:       w_NextState = S_BRANCH;
          OP_J:         w_NextState = S_JUMP;
          OP_ADDI:      w_NextState = S_ADDIEXEC;
          default: begin
            w_NextState = S_FETCH;
            w_Illegal   = 1'b1;
          end
        endcase
      end
      S_MEMADDR: begin
        // Only lw/sw reach here, so anything not lw is treated as sw
        w_NextState = (i_Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_NextState = i_MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_NextState = S_FETCH;
        w_Retire    = 1'b1;
      end
      S_MEMWRITE: begin
        w_NextState = i_MemReady ? S_FETCH : S_MEMWRITE;
        w_Retire    = i_MemReady;
      end
      S_EXECUTE: begin
        w_NextState = S_RWB;
      end
      S_RWB: begin
        w_NextState = S_FETCH;
        w_Retire    = 1'b1;
      end
      S_BRANCH: begin
        w_NextState = S_FETCH;
        w_Retire    = 1'b1;
      end
      S_JUMP: begin
        w_NextState = S_FETCH;
        w_Retire    = 1'b1;
      end
      S_ADDIEXEC: begin
        w_NextState = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_NextState = S_FETCH;
        w_Retire    = 1'b1;
      end
      default: begin
        w_NextState = S_FETCH;
      end
    endcase
  end

  // Moore output decode; held low while reset is asserted so no strobe
  // (notably RegWrite) survives an asynchronous reset mid-instruction
  always_comb begin
    o_ALUOp       = ALUOP_ADD;
    o_ALUSrcA     = 1'b0;
    o_ALUSrcB     = SRCB_REGB;
    o_PCSource    = PCSRC_ALU;
    o_PCWrite     = 1'b0;
    o_PCWriteCond = 1'b0;
    o_IorD        = 1'b0;
    o_MemRead     = 1'b0;
    o_MemWrite    = 1'b0;
    o_IRWrite     = 1'b0;
    o_MemtoReg    = 1'b0;
    o_RegDst      = 1'b0;
    o_RegWrite    = 1'b0;
    if (i_Rst_n) begin
      case (r_State)
        S_FETCH: begin
          o_MemRead  = 1'b1;
          o_ALUSrcB  = SRCB_FOUR;
          o_ALUOp    = ALUOP_ADD;
          o_PCSource = PCSRC_ALU;
          // PC+4 and IR load only in the cycle the fetch completes
          o_IRWrite  = i_MemReady;
          o_PCWrite  = i_MemReady;
        end
        S_DECODE: begin
          o_ALUSrcB = SRCB_IMMSH;
          o_ALUOp   = ALUOP_ADD;
        end
        S_MEMADDR: begin
          o_ALUSrcA = 1'b1;
          o_ALUSrcB = SRCB_IMM;
          o_ALUOp   = ALUOP_ADD;
        end
        S_MEMREAD: begin
          o_MemRead = 1'b1;
          o_IorD    = 1'b1;
        end
        S_MEMWB: begin
          o_RegWrite = 1'b1;
          o_MemtoReg = 1'b1;
          o_RegDst   = 1'b0;
        end
        S_MEMWRITE: begin
          o_MemWrite = 1'b1;
          o_IorD     = 1'b1;
        end
        S_EXECUTE: begin
          o_ALUSrcA = 1'b1;
          o_ALUSrcB = SRCB_REGB;
          o_ALUOp   = ALUOP_FUNCT;
        end
        S_RWB: begin
          o_RegWrite = 1'b1;
          o_RegDst   = 1'b1;
        end
        S_BRANCH: begin
          o_ALUSrcA     = 1'b1;
          o_ALUSrcB     = SRCB_REGB;
          o_ALUOp       = ALUOP_SUB;
          o_PCWriteCond = 1'b1;
          o_PCSource    = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          o_PCWrite  = 1'b1;
          o_PCSource = PCSRC_JUMP;
        end
        S_ADDIEXEC: begin
          o_ALUSrcA = 1'b1;
          o_ALUSrcB = SRCB_IMM;
          o_ALUOp   = ALUOP_ADD;
        end
        S_ADDIWB: begin
          o_RegWrite = 1'b1;
          o_RegDst   = 1'b0;
          o_MemtoReg = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Illegal-opcode flag: visible in the FETCH cycle after the bad DECODE
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_IllegalOp <= 1'b0;
    end else begin
      r_IllegalOp <= w_Illegal;
    end
  end

  // Retired-instruction counter, natural wrap
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_InstrCount <= '0;
    end else if (w_Retire) begin
      r_InstrCount <= r_InstrCount + COUNT_W'(1);
    end
  end

  assign o_IllegalOp  = r_IllegalOp;
  assign o_InstrCount = r_InstrCount;
  assign o_State      = r_State;

endmodule

// File: tb/tb_multicycle_main_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_main_control
//   Scoreboard bench: the stimulus process drives one directed vector per
//   cycle and pushes the hand-derived expected outputs; a monitor pops and
//   compares on the falling edge. A second instance with a 2-bit counter
//   checks modulo wrap of the retirement count.
// -----------------------------------------------------------------------------
module tb_multicycle_main_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;

  logic [1:0]  alu_op, alu_src_b, pc_source;
  logic        alu_src_a, pc_write, pc_write_cond, iord, mem_read, mem_write;
  logic        ir_write, mem_to_reg, reg_dst, reg_write, illegal_op;
  logic [3:0]  state;
  logic [31:0] instr_count;

  logic [1:0]  w_alu_op, w_alu_src_b, w_pc_source;
  logic        w_alu_src_a, w_pc_write, w_pc_write_cond, w_iord, w_mem_read, w_mem_write;
  logic        w_ir_write, w_mem_to_reg, w_reg_dst, w_reg_write, w_illegal_op;
  logic [3:0]  w_state;
  logic [1:0]  w_instr_count;

  multicycle_main_control #(.COUNT_W(32)) u_dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Opcode(opcode), .i_MemReady(mem_ready),
    .o_ALUOp(alu_op), .o_ALUSrcA(alu_src_a), .o_ALUSrcB(alu_src_b),
    .o_PCSource(pc_source), .o_PCWrite(pc_write), .o_PCWriteCond(pc_write_cond),
    .o_IorD(iord), .o_MemRead(mem_read), .o_MemWrite(mem_write),
    .o_IRWrite(ir_write), .o_MemtoReg(mem_to_reg), .o_RegDst(reg_dst),
    .o_RegWrite(reg_write), .o_IllegalOp(illegal_op), .o_State(state),
    .o_InstrCount(instr_count)
  );

  multicycle_main_control #(.COUNT_W(2)) u_dut_wrap (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Opcode(opcode), .i_MemReady(mem_ready),
    .o_ALUOp(w_alu_op), .o_ALUSrcA(w_alu_src_a), .o_ALUSrcB(w_alu_src_b),
    .o_PCSource(w_pc_source), .o_PCWrite(w_pc_write), .o_PCWriteCond(w_pc_write_cond),
    .o_IorD(w_iord), .o_MemRead(w_mem_read), .o_MemWrite(w_mem_write),
    .o_IRWrite(w_ir_write), .o_MemtoReg(w_mem_to_reg), .o_RegDst(w_reg_dst),
    .o_RegWrite(w_reg_write), .o_IllegalOp(w_illegal_op), .o_State(w_state),
    .o_InstrCount(w_instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control bundle: {ALUOp, SrcA, SrcB, PCSource, PCWrite, PCWriteCond,
  //                  IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite}
  localparam logic [15:0] C_ZERO     = 16'h0000;
  localparam logic [15:0] C_FETCH    = {2'b00, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [15:0] C_FSTALL   = {2'b00, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [15:0] C_DECODE   = {2'b00, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [15:0] C_MEMADDR  = {2'b00, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [15:0] C_MEMREAD  = {2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [15:0] C_MEMWB    = {2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [15:0] C_MEMWRITE = {2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [15:0] C_EXECUTE  = {2'b10, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [15:0] C_RWB      = {2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [15:0] C_BRANCH   = {2'b01, 1'b1, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [15:0] C_JUMP     = {2'b00, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [15:0] C_ADDIEX   = {2'b00, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [15:0] C_ADDIWB   = {2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct {
    int          idx;
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic [31:0] cnt;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [15:0] ctrl_bus;
  assign ctrl_bus = {alu_op, alu_src_a, alu_src_b, pc_source, pc_write, pc_write_cond,
                     iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write};

  // Drive one cycle of inputs and queue the outputs expected in that cycle
  task automatic step(input logic [5:0] op, input logic rdy, input logic rst,
                      input logic [3:0] st, input logic [15:0] ctrl,
                      input logic [31:0] cnt, input logic ill);
    exp_t e;
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = rdy;
    rst_n     = rst;
    e.idx  = n_vec;
    e.st   = st;
    e.ctrl = ctrl;
    e.cnt  = cnt;
    e.ill  = ill;
    sb_q.push_back(e);
    n_vec++;
  endtask

  // Monitor: outputs are valid every cycle, compare on the falling edge
  initial begin
    exp_t e;
    logic [1:0] exp_wrap;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        exp_wrap = e.cnt[1:0];
        n_cmp++;
        if (state !== e.st) begin
          n_fail++;
          $display("FAIL vec%0d state: got %0d expected %0d", e.idx, state, e.st);
        end
        n_cmp++;
        if (ctrl_bus !== e.ctrl) begin
          n_fail++;
          $display("FAIL vec%0d ctrl: got %h expected %h", e.idx, ctrl_bus, e.ctrl);
        end
        n_cmp++;
        if (instr_count !== e.cnt) begin
          n_fail++;
          $display("FAIL vec%0d count: got %0d expected %0d", e.idx, instr_count, e.cnt);
        end
        n_cmp++;
        if (illegal_op !== e.ill) begin
          n_fail++;
          $display("FAIL vec%0d illegal: got %b expected %b", e.idx, illegal_op, e.ill);
        end
        n_cmp++;
        if (w_instr_count !== exp_wrap) begin
          n_fail++;
          $display("FAIL vec%0d wrap_count: got %0d expected %0d", e.idx, w_instr_count, exp_wrap);
        end
        n_cmp++;
        if (w_state !== e.st) begin
          n_fail++;
          $display("FAIL vec%0d wrap_state: got %0d expected %0d", e.idx, w_state, e.st);
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    opcode    = 6'd0;
    mem_ready = 1'b1;

    // Reset held: everything zero
    step(LW,  1'b1, 1'b0, 4'd0,  C_ZERO,     0, 1'b0);
    step(LW,  1'b1, 1'b0, 4'd0,  C_ZERO,     0, 1'b0);
    // lw, no stalls: 0,1,2,3,4 then count 1
    step(LW,  1'b1, 1'b1, 4'd0,  C_FETCH,    0, 1'b0);
    step(LW,  1'b1, 1'b1, 4'd1,  C_DECODE,   0, 1'b0);
    step(LW,  1'b1, 1'b1, 4'd2,  C_MEMADDR,  0, 1'b0);
    step(LW,  1'b1, 1'b1, 4'd3,  C_MEMREAD,  0, 1'b0);
    step(LW,  1'b1, 1'b1, 4'd4,  C_MEMWB,    0, 1'b0);
    // R-type
    step(RT,  1'b1, 1'b1, 4'd0,  C_FETCH,    1, 1'b0);
    step(RT,  1'b1, 1'b1, 4'd1,  C_DECODE,   1, 1'b0);
    step(RT,  1'b1, 1'b1, 4'd6,  C_EXECUTE,  1, 1'b0);
    step(RT,  1'b1, 1'b1, 4'd7,  C_RWB,      1, 1'b0);
    // beq
    step(BEQ, 1'b1, 1'b1, 4'd0,  C_FETCH,    2, 1'b0);
    step(BEQ, 1'b1, 1'b1, 4'd1,  C_DECODE,   2, 1'b0);
    step(BEQ, 1'b1, 1'b1, 4'd8,  C_BRANCH,   2, 1'b0);
    // sw with three not-ready cycles in MEMWRITE
    step(SW,  1'b1, 1'b1, 4'd0,  C_FETCH,    3, 1'b0);
    step(SW,  1'b1, 1'b1, 4'd1,  C_DECODE,   3, 1'b0);
    step(SW,  1'b1, 1'b1, 4'd2,  C_MEMADDR,  3, 1'b0);
    step(SW,  1'b0, 1'b1, 4'd5,  C_MEMWRITE, 3, 1'b0);
    step(SW,  1'b0, 1'b1, 4'd5,  C_MEMWRITE, 3, 1'b0);
    step(SW,  1'b0, 1'b1, 4'd5,  C_MEMWRITE, 3, 1'b0);
    step(SW,  1'b1, 1'b1, 4'd5,  C_MEMWRITE, 3, 1'b0);
    // Illegal opcode: pulse for one cycle, count unchanged; then fetch stall x2
    step(BAD, 1'b1, 1'b1, 4'd0,  C_FETCH,    4, 1'b0);
    step(BAD, 1'b1, 1'b1, 4'd1,  C_DECODE,   4, 1'b0);
    step(JMP, 1'b0, 1'b1, 4'd0,  C_FSTALL,   4, 1'b1);
    step(JMP, 1'b0, 1'b1, 4'd0,  C_FSTALL,   4, 1'b0);
    step(JMP, 1'b1, 1'b1, 4'd0,  C_FETCH,    4, 1'b0);
    // j
    step(JMP, 1'b1, 1'b1, 4'd1,  C_DECODE,   4, 1'b0);
    step(JMP, 1'b1, 1'b1, 4'd9,  C_JUMP,     4, 1'b0);
    // addi
    step(ADDI, 1'b1, 1'b1, 4'd0,  C_FETCH,   5, 1'b0);
    step(ADDI, 1'b1, 1'b1, 4'd1,  C_DECODE,  5, 1'b0);
    step(ADDI, 1'b1, 1'b1, 4'd10, C_ADDIEX,  5, 1'b0);
    step(ADDI, 1'b1, 1'b1, 4'd11, C_ADDIWB,  5, 1'b0);
    // lw with one read stall, reset dropped during MEMWB
    step(LW,  1'b1, 1'b1, 4'd0,  C_FETCH,    6, 1'b0);
    step(LW,  1'b1, 1'b1, 4'd1,  C_DECODE,   6, 1'b0);
    step(LW,  1'b1, 1'b1, 4'd2,  C_MEMADDR,  6, 1'b0);
    step(LW,  1'b0, 1'b1, 4'd3,  C_MEMREAD,  6, 1'b0);
    step(LW,  1'b1, 1'b1, 4'd3,  C_MEMREAD,  6, 1'b0);
    step(LW,  1'b1, 1'b0, 4'd0,  C_ZERO,     0, 1'b0);
    step(LW,  1'b1, 1'b0, 4'd0,  C_ZERO,     0, 1'b0);
    // Recovery after reset: j retires, count restarts at 1
    step(JMP, 1'b1, 1'b1, 4'd0,  C_FETCH,    0, 1'b0);
    step(JMP, 1'b1, 1'b1, 4'd1,  C_DECODE,   0, 1'b0);
    step(JMP, 1'b1, 1'b1, 4'd9,  C_JUMP,     0, 1'b0);
    step(JMP, 1'b1, 1'b1, 4'd0,  C_FETCH,    1, 1'b0);

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d queued expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
